// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// errors, synchronous flush and a selectable first-word-fall-through read.
module sync_fifo_param #(
    parameter int WIDTH  = 3,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           datin,
    input  logic                       rd,
    output logic [WIDTH-1:0]           datout,
    output logic                       dato,
    output logic                       full,
    output logic                       empy,
    output logic                       afull,
    output logic                       aempy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             ra;
    logic             wa;
    logic [CW-1:0]    count_next;

    // Accept logic: a read needs a stored word; a write into a full FIFO is
    // only allowed when a read frees a slot in the same cycle. Flush blocks both.
    always_comb begin
        ra         = 1'b0;
        wa         = 1'b0;
        count_next = count;
        if (!clr) begin
            ra = rd & ~empy;
            wa = wr & (~full | ra);
        end
        count_next = count + CW'(wa) - CW'(ra);
    end

    // Pointers, occupancy and the registered status flags derived from count_next.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empy  <= 1'b1;
            afull <= 1'b0;
            aempy <= 1'b1;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empy  <= 1'b1;
            afull <= (AF_C == '0);
            aempy <= 1'b1;
        end else begin
            if (wa) begin
                wptr <= wptr + AW'(1);
            end
            if (ra) begin
                rptr <= rptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empy  <= (count_next == '0);
            afull <= (count_next >= AF_C);
            aempy <= (count_next <= AE_C);
        end
    end

    // Sticky error flags: only reset clears them, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (!clr) begin
            if (wr && !wa) begin
                ovf <= 1'b1;
            end
            if (rd && empy) begin
                udf <= 1'b1;
            end
        end
    end

    // Storage array; intentionally not reset, and never written while in reset.
    always_ff @(posedge clk) begin
        if (wa && !rst) begin
            mem[wptr] <= datin;
        end
    end

    generate
        if (FWFT == 0) begin : g_registered
            // Registered read: the popped word and its one-cycle valid strobe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    datout <= '0;
                    dato   <= 1'b0;
                end else begin
                    dato <= ra;
                    if (ra) begin
                        datout <= mem[rptr];
                    end
                end
            end
        end else begin : g_fwft
            // Head word always presented; forced to zero while nothing is stored.
            always_comb begin
                datout = '0;
                if (!empy) begin
                    datout = mem[rptr];
                end
                dato = ~empy;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives a registered-read and an FWFT instance with the
// same stimulus and checks both against a queue-based reference model.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [2:0] datin = '0;

    logic [2:0] datout_r, datout_f;
    logic       dato_r, dato_f;
    logic       full_r, full_f;
    logic       empy_r, empy_f;
    logic       afull_r, afull_f;
    logic       aempy_r, aempy_f;
    logic [3:0] count_r, count_f;
    logic       ovf_r, ovf_f;
    logic       udf_r, udf_f;

    int checks = 0;
    int failures = 0;

    logic [2:0] sb[$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    sync_fifo_param #(.WIDTH(3), .DEPTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .datin(datin), .rd(rd),
        .datout(datout_r), .dato(dato_r), .full(full_r), .empy(empy_r),
        .afull(afull_r), .aempy(aempy_r), .count(count_r), .ovf(ovf_r), .udf(udf_r)
    );

    sync_fifo_param #(.WIDTH(3), .DEPTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(1)) dut_fw (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .datin(datin), .rd(rd),
        .datout(datout_f), .dato(dato_f), .full(full_f), .empy(empy_f),
        .afull(afull_f), .aempy(aempy_f), .count(count_f), .ovf(ovf_f), .udf(udf_f)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compares every observable output of both instances against the model.
    task automatic checkState(input bit popped, input logic [2:0] exp_word);
        int n;
        logic [2:0] head;
        n = sb.size();
        head = (n != 0) ? sb[0] : 3'd0;
        checkOutput("count", 32'(count_r), 32'(n));
        checkOutput("full", 32'(full_r), 32'(n == 8));
        checkOutput("empy", 32'(empy_r), 32'(n == 0));
        checkOutput("afull", 32'(afull_r), 32'(n >= 6));
        checkOutput("aempy", 32'(aempy_r), 32'(n <= 2));
        checkOutput("ovf", 32'(ovf_r), 32'(m_ovf));
        checkOutput("udf", 32'(udf_r), 32'(m_udf));
        checkOutput("dato", 32'(dato_r), 32'(popped));
        if (popped) begin
            checkOutput("datout", 32'(datout_r), 32'(exp_word));
        end
        checkOutput("fw_count", 32'(count_f), 32'(n));
        checkOutput("fw_dato", 32'(dato_f), 32'(n != 0));
        checkOutput("fw_datout", 32'(datout_f), 32'(head));
        checkOutput("fw_ovf", 32'(ovf_f), 32'(m_ovf));
        checkOutput("fw_udf", 32'(udf_f), 32'(m_udf));
    endtask

    // One clock of stimulus; the model predicts acceptance from pre-edge state.
    task automatic applyStimulus(input bit w, input logic [2:0] d, input bit r, input bit c);
        bit m_empty, m_full, ra, wa;
        logic [2:0] exp_word;
        wr = w;
        datin = d;
        rd = r;
        clr = c;
        m_empty = (sb.size() == 0);
        m_full = (sb.size() == 8);
        ra = r && !m_empty && !c;
        wa = w && (!m_full || ra) && !c;
        exp_word = 3'd0;
        @(posedge clk);
        #1;
        if (c) begin
            sb.delete();
        end else begin
            if (ra) exp_word = sb.pop_front();
            if (wa) sb.push_back(d);
            if (w && !wa) m_ovf = 1'b1;
            if (r && m_empty) m_udf = 1'b1;
        end
        wr = 1'b0;
        rd = 1'b0;
        clr = 1'b0;
        checkState(ra, exp_word);
    endtask

    // Holds reset for some cycles, optionally with a write burst underneath.
    task automatic resetDut(input int cycles, input bit burst);
        rst = 1'b1;
        wr = burst;
        rd = burst;
        clr = burst;
        datin = 3'd7;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        clr = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        checkState(1'b0, 3'd0);
        checkOutput("rst_datout", 32'(datout_r), 32'd0);
    endtask

    initial begin
        logic [2:0] fill_a[8];
        logic [2:0] fill_b[3];
        fill_a = '{3'd2, 3'd6, 3'd4, 3'd1, 3'd7, 3'd4, 3'd1, 3'd5};
        fill_b = '{3'd3, 3'd0, 3'd2};

        $display("[TB] reset");
        resetDut(2, 1'b0);

        $display("[TB] fill and wrap");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, fill_a[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, fill_b[i], 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

        $display("[TB] overflow");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i + 1), 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

        $display("[TB] underflow and simultaneous access");
        resetDut(1, 1'b0);
        applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(7 - i), 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd6, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);

        $display("[TB] flush and mid-operation reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd4, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'(i + 2), 1'b0, 1'b0);
        resetDut(1, 1'b1);

        $display("[TB] first-word-fall-through");
        applyStimulus(1'b1, 3'd6, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            bit w, r, c;
            w = ($urandom_range(0, 3) != 0) ? (i % 80 < 40) : ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0) ? (i % 80 >= 40) : ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 63) == 0);
            applyStimulus(w, 3'($urandom_range(0, 7)), r, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
